// File: rtl/fpu_muladd_arbiter_pkg.sv
// Shared types and constants for the fused multiply-add arbiter.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int NREQ_MAX = 8;

  // Grant index width; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_muladd_arbiter_if.sv
// Requester-side and unit-side signals of the multiply-add arbiter.
interface fpu_muladd_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    i_request;
  logic [NREQ*32-1:0] i_op1;
  logic [NREQ*32-1:0] i_op2;
  logic [NREQ*32-1:0] i_op3;
  logic [NREQ-1:0]    o_ready;
  logic [31:0]        o_result;
  logic               o_fpu_request;
  logic [31:0]        o_fpu_op1;
  logic [31:0]        o_fpu_op2;
  logic [31:0]        o_fpu_op3;
  logic               i_fpu_ready;
  logic [31:0]        i_fpu_result;

  modport slave (
    input  i_request, i_op1, i_op2, i_op3, i_fpu_ready, i_fpu_result,
    output o_ready, o_result, o_fpu_request, o_fpu_op1, o_fpu_op2, o_fpu_op3
  );

  modport master (
    output i_request, i_op1, i_op2, i_op3, i_fpu_ready, i_fpu_result,
    input  o_ready, o_result, o_fpu_request, o_fpu_op1, o_fpu_op2, o_fpu_op3
  );
endinterface

// File: rtl/fpu_muladd_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module fpu_rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_request,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_index
);
  logic [NREQ-1:0] rotated;
  logic [IW-1:0]   offset;
  logic [IW:0]     sum;

  // Rotate so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    rotated = NREQ'({i_request, i_request} >> i_ptr);
    offset  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IW'(i);
    end
    sum = {1'b0, i_ptr} + {1'b0, offset};
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    o_index = sum[IW-1:0];
  end

  assign o_valid = |i_request;
endmodule

// File: rtl/fpu_muladd_arbiter.sv
// Shares one multi-cycle fused multiply-add unit between NREQ requesters
// using round-robin grants and the unit's level request/ready handshake.
module fpu_muladd_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  fpu_muladd_arbiter_if.slave   bus
);
  localparam int IW = idx_width(NREQ);

  state_t          state, state_n;
  logic [IW-1:0]   grant, grant_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [NREQ-1:0] ready, ready_n;
  logic [31:0]     result, result_n;
  logic            fpu_req, fpu_req_n;
  logic [31:0]     op1, op1_n, op2, op2_n, op3, op3_n;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   next_ptr;

  fpu_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .i_request (bus.i_request),
    .i_ptr     (rr_ptr),
    .o_valid   (pick_vld),
    .o_index   (pick_idx)
  );

  assign next_ptr = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      ready   <= '0;
      result  <= '0;
      fpu_req <= 1'b0;
      op1     <= '0;
      op2     <= '0;
      op3     <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      rr_ptr  <= rr_ptr_n;
      ready   <= ready_n;
      result  <= result_n;
      fpu_req <= fpu_req_n;
      op1     <= op1_n;
      op2     <= op2_n;
      op3     <= op3_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    rr_ptr_n  = rr_ptr;
    ready_n   = ready;
    result_n  = result;
    fpu_req_n = fpu_req;
    op1_n     = op1;
    op2_n     = op2;
    op3_n     = op3;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_n   = pick_idx;
          op1_n     = bus.i_op1[32*pick_idx +: 32];
          op2_n     = bus.i_op2[32*pick_idx +: 32];
          op3_n     = bus.i_op3[32*pick_idx +: 32];
          fpu_req_n = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_fpu_ready) begin
          result_n = bus.i_fpu_result;
          if (bus.i_request[grant]) begin
            ready_n        = '0;
            ready_n[grant] = 1'b1;
            state_n        = RESPOND;
          end else begin
            // Requester gave up: the unit cannot abort, so finish and discard.
            fpu_req_n = 1'b0;
            rr_ptr_n  = next_ptr;
            state_n   = DRAIN;
          end
        end
      end
      RESPOND: begin
        if (!bus.i_request[grant]) begin
          ready_n   = '0;
          fpu_req_n = 1'b0;
          rr_ptr_n  = next_ptr;
          state_n   = DRAIN;
        end
      end
      DRAIN: begin
        // Unit must be back in its idle state before the next issue.
        if (!bus.i_fpu_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_ready       = ready;
  assign bus.o_result      = result;
  assign bus.o_fpu_request = fpu_req;
  assign bus.o_fpu_op1     = op1;
  assign bus.o_fpu_op2     = op2;
  assign bus.o_fpu_op3     = op3;
endmodule

// File: doc/fpu_muladd_arbiter.md
Name: fpu_muladd_arbiter

Overview:
- Shares one multi-cycle fused multiply-add unit (IDLE→…→PUT_Z sequencer, level request/ready handshake) between NREQ independent requesters, e.g. FPU issue slot and a vector/microcode sequencer.
- Round-robin arbitration.
- Latches operands at grant and drives the unit's request/operand inputs.
- Returns the result to the granted requester with the same level handshake the unit uses.

Parameters:
NREQ, 2, number of requesters (2..8)
IW, $clog2(NREQ) (min 1), grant index width (derived, localparam)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_request  in  NREQ  per-requester level request, held until matching o_ready[k]
i_op1  in  NREQ*32  flattened operand a, slice k = [32k+31:32k]
i_op2  in  NREQ*32  flattened operand b
i_op3  in  NREQ*32  flattened addend c
o_ready  out  NREQ  per-requester completion, one-hot or zero
o_result  out  32  result, valid while any o_ready bit high
o_fpu_request  out  1  to unit i_request
o_fpu_op1  out  32  to unit i_op1
o_fpu_op2  out  32  to unit i_op2
o_fpu_op3  out  32  to unit i_op3
i_fpu_ready  in  1  from unit o_ready
i_fpu_result  in  32  from unit o_result

Behaviour:
- One clock (i_clock); reset synchronous, active-high on i_reset.
- Reset values: o_ready=0, o_result=0, o_fpu_request=0, o_fpu_op1/2/3=0, state=IDLE, rr pointer=0, grant=0.
- IDLE:
  - If any i_request bit set, pick the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - Register grant=k, latch op slices k into o_fpu_op1/2/3, set o_fpu_request=1, go ISSUE.
  - The unit sees the request the cycle after the arbiter samples it.
- ISSUE: hold o_fpu_request and operands stable; wait for i_fpu_ready=1. Then:
  - Capture o_result=i_fpu_result.
  - If i_request[grant] is still 1: set o_ready[grant]=1, go RESPOND.
  - Otherwise (requester abandoned): drop o_fpu_request, go DRAIN, no o_ready.
- RESPOND: hold o_ready[grant] and o_result. When i_request[grant]=0:
  - o_ready=0, o_fpu_request=0, rr pointer=(grant+1) mod NREQ, go DRAIN.
- DRAIN: wait for i_fpu_ready=0, then go IDLE. This guarantees the unit has returned to IDLE before the next issue. No new grant is made in DRAIN.
- Abandonment mid-operation: the unit cannot abort.
  - Arbiter completes the operation and discards the result.
  - rr pointer still advances to grant+1.
  - A re-raised request from the same requester is treated as new and is not granted until DRAIN completes.
- Operands are latched only at grant; requester-side operand changes after grant are ignored.
- Simultaneous requests: exactly one grant per operation. Non-granted requests remain pending with o_ready=0.
- Fairness: a continuously requesting requester cannot be granted twice while another requester is pending.
- Minimum turnaround: 1 (IDLE) + unit latency + 1 (RESPOND, ≥1 cycle) + 1 (DRAIN) cycles per operation.
- Invariant: at most one o_ready bit high. o_fpu_request is never high in IDLE.
- Reset at any state: immediate return to reset values next edge. The unit shares i_reset, so no drain is needed.
- NREQ=1: pointer is constant 0; behaviour otherwise identical.

Decomposition:
- Package fpu_arb_pkg:
  - state_t enum {IDLE, ISSUE, RESPOND, DRAIN} (bit [1:0]).
  - Constant NREQ_MAX=8.
- One sub-module, fpu_rr_picker:
  - Combinational.
  - Inputs: request vector and pointer.
  - Outputs: valid and index.
  - Implemented as double-width rotate plus priority encode.

Test Plan:
- Req0 only, op1=3F800000 op2=40000000 op3=3F000000 (1.0*2.0+0.5) → o_ready=01, o_result=40200000; after req0 drops, o_fpu_request=0 next cycle, IDLE after unit ready drops.
- Req0 and req1 raised in the same cycle after reset, each 40400000*40400000+00000000 → req0 served first (41100000), then req1 (41100000); never both o_ready bits set.
- Req0 held continuously (re-raised right after each ready), req1 pending → grants alternate 0,1,0,1 across 4 operations.
- Req1 drops request while unit busy → no o_ready[1]; o_fpu_request falls after unit ready; the next operation for req0 yields the correct result with no stale result.
- Operands of granted requester changed one cycle after grant → result matches the originally latched operands.
- i_reset asserted during ISSUE → next cycle all outputs 0, state IDLE; a new request then completes normally.
